// File: rtl/mem_responder.sv
// Word-addressed wait-state memory on the multicycle core's memory port. It serves one request
// at a time and completes it LATENCY edges after acceptance with a one-cycle MemReady strobe.
module mem_responder #(
   parameter int DEPTH_LOG2 = 6,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        AdrErr,
   output logic        Busy
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam logic [3:0] LOAD = 4'(LATENCY - 1);

   state_t      state_reg;
   logic [3:0]  count_reg;
   logic [31:0] adr_reg;
   logic [31:0] wdata_reg;
   logic        write_reg;
   logic [31:0] mem [2**DEPTH_LOG2];

   logic                  accept;
   logic                  commit;
   logic                  cur_write;
   logic                  cur_err;
   logic [31:0]           cur_adr;
   logic [31:0]           cur_wdata;
   logic [DEPTH_LOG2-1:0] cur_idx;

   // With LATENCY=1 the commit lands on the accepting edge, so it must see the live inputs.
   always_comb begin
      accept    = (state_reg == IDLE) && MemReq;
      commit    = (accept && (LOAD == 4'd0)) || ((state_reg == WAIT) && (count_reg == 4'd1));
      cur_adr   = (state_reg == IDLE) ? Adr : adr_reg;
      cur_wdata = (state_reg == IDLE) ? WriteData : wdata_reg;
      cur_write = (state_reg == IDLE) ? MemWrite : write_reg;
      cur_idx   = cur_adr[DEPTH_LOG2+1:2];
      cur_err   = (cur_adr[1:0] != 2'b00) || (cur_adr[31:DEPTH_LOG2+2] != '0);
   end

   // Storage is not reset; reset only blocks a commit that would coincide with it.
   always_ff @(posedge clk) begin
      if (commit && cur_write && !cur_err && !reset)
         mem[cur_idx] <= cur_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= 4'd0;
         adr_reg   <= '0;
         wdata_reg <= '0;
         write_reg <= 1'b0;
         ReadData  <= '0;
         MemReady  <= 1'b0;
         AdrErr    <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         MemReady <= 1'b0;
         AdrErr   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  adr_reg   <= Adr;
                  wdata_reg <= WriteData;
                  write_reg <= MemWrite;
                  count_reg <= LOAD;
                  Busy      <= 1'b1;
                  state_reg <= (LOAD == 4'd0) ? DONE : WAIT;
               end
            end
            WAIT: begin
               count_reg <= count_reg - 4'd1;
               if (count_reg == 4'd1)
                  state_reg <= DONE;
            end
            default: begin
               state_reg <= IDLE;
               Busy      <= 1'b0;
            end
         endcase
         if (commit) begin
            MemReady <= 1'b1;
            AdrErr   <= cur_err;
            if (!cur_write)
               ReadData <= cur_err ? '0 : mem[cur_idx];
         end
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table of requests with a timing-aware scoreboard, hand sequences for
// busy/ignore and reset-during-wait, and LATENCY=1/4 instances for back-to-back spacing.
module tb_mem_responder;
   localparam int LAT = 2;

   logic        clk;
   logic        reset;
   logic        MemReq, MemWrite;
   logic [31:0] Adr, WriteData, ReadData;
   logic        MemReady, AdrErr, Busy;

   // Shared stimulus for the LATENCY=1 and LATENCY=4 instances
   logic        l_req, l_we, l_rd_phase;
   logic [31:0] l_adr, l_wd, l1_adr, l4_adr;
   logic [31:0] l1_rd, l4_rd;
   logic        l1_rdy, l1_err, l1_busy, l4_rdy, l4_err, l4_busy;
   int          l1_n = 0, l4_n = 0, l1_t0 = 0, l4_t0 = 0;

   int checks = 0, errors = 0, cycle = 0, ready_cnt = 0;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t vecs[15];

   mem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite), .Adr(Adr),
      .WriteData(WriteData), .ReadData(ReadData), .MemReady(MemReady), .AdrErr(AdrErr), .Busy(Busy));

   mem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .MemReq(l_req), .MemWrite(l_we), .Adr(l1_adr),
      .WriteData(l_wd), .ReadData(l1_rd), .MemReady(l1_rdy), .AdrErr(l1_err), .Busy(l1_busy));

   mem_responder #(.DEPTH_LOG2(6), .LATENCY(4)) u_l4 (
      .clk(clk), .reset(reset), .MemReq(l_req), .MemWrite(l_we), .Adr(l4_adr),
      .WriteData(l_wd), .ReadData(l4_rd), .MemReady(l4_rdy), .AdrErr(l4_err), .Busy(l4_busy));

   assign l1_adr = l_we ? l_adr : ((l1_n == 0) ? 32'h0 : 32'h4);
   assign l4_adr = l_we ? l_adr : ((l4_n == 0) ? 32'h0 : 32'h4);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest outstanding request, including its cycle.
   always @(negedge clk) begin
      if (!reset && MemReady) begin
         exp_t e;
         ready_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_ready", 32'(MemReady), 32'd0);
         end else begin
            e = sb.pop_front();
            $display("txn adr=%h rd=%h err=%0d cycle=%0d", e.adr, ReadData, AdrErr, cycle);
            check("rdata", ReadData, e.rd);
            check("adrerr", 32'(AdrErr), 32'(e.err));
            check("ready_cycle", 32'(cycle), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (l_rd_phase && l1_rdy) begin
         if (l1_n == 0) begin
            check("l1_rd0", l1_rd, 32'h01010101);
            l1_t0 = cycle;
         end else if (l1_n == 1) begin
            check("l1_rd1", l1_rd, 32'h02020202);
            check("l1_spacing", 32'(cycle - l1_t0), 32'd2);
         end
         l1_n++;
      end
   end

   always @(negedge clk) begin
      if (l_rd_phase && l4_rdy) begin
         if (l4_n == 0) begin
            check("l4_rd0", l4_rd, 32'h01010101);
            l4_t0 = cycle;
         end else if (l4_n == 1) begin
            check("l4_rd1", l4_rd, 32'h02020202);
            check("l4_spacing", 32'(cycle - l4_t0), 32'd5);
         end
         l4_n++;
      end
   end

   task automatic wait_ready(input int target, input string name);
      for (int k = 0; k < 40 && ready_cnt < target; k++) @(negedge clk);
      if (ready_cnt < target) check(name, 32'(ready_cnt), 32'(target));
   endtask

   task automatic run_req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
      int target;
      exp_t e;
      target = ready_cnt + 1;
      @(negedge clk);
      MemReq = 1'b1; MemWrite = we; Adr = adr; WriteData = wd;
      e.adr = adr; e.rd = exp_rd; e.err = exp_err; e.cyc = cycle + LAT;
      sb.push_back(e);
      @(negedge clk);
      MemReq = 1'b0;
      wait_ready(target, "ready_timeout");
      @(negedge clk);
      check("strobe_cleared", 32'(MemReady), 32'd0);
      check("rdata_held", ReadData, exp_rd);
      check("busy_idle", 32'(Busy), 32'd0);
   endtask

   initial begin
      int start;
      exp_t e;
      vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h00,       32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b1, 32'h20,       32'h20202020, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 32'h13,       32'h0,        32'h00000000, 1'b1};
      vecs[5]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b1, 32'h100,      32'h12345678, 32'hDEADBEEF, 1'b1};
      vecs[7]  = '{1'b0, 32'h00,       32'h0,        32'hA5A5A5A5, 1'b0};
      vecs[8]  = '{1'b1, 32'h08,       32'h11111111, 32'hA5A5A5A5, 1'b0};
      vecs[9]  = '{1'b1, 32'hFC,       32'hCAFEF00D, 32'hA5A5A5A5, 1'b0};
      vecs[10] = '{1'b0, 32'hFC,       32'h0,        32'hCAFEF00D, 1'b0};
      vecs[11] = '{1'b1, 32'h11,       32'h0BADF00D, 32'hCAFEF00D, 1'b1};
      vecs[12] = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
      vecs[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1};
      vecs[14] = '{1'b0, 32'h20,       32'h0,        32'h20202020, 1'b0};

      reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Adr = '0; WriteData = '0;
      l_req = 1'b0; l_we = 1'b0; l_adr = '0; l_wd = '0; l_rd_phase = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_rdata", ReadData, 32'h0);
      check("reset_ready", 32'(MemReady), 32'd0);
      check("reset_adrerr", 32'(AdrErr), 32'd0);
      check("reset_busy", 32'(Busy), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++)
         run_req(vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err);

      // Requests held high through WAIT and DONE must be ignored until IDLE.
      start = ready_cnt;
      @(negedge clk);
      MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h10;
      e.adr = 32'h10; e.rd = 32'hDEADBEEF; e.err = 1'b0; e.cyc = cycle + LAT;
      sb.push_back(e);
      @(negedge clk);
      Adr = 32'h20;
      check("busy_wait", 32'(Busy), 32'd1);
      @(negedge clk);
      check("busy_done", 32'(Busy), 32'd1);
      @(negedge clk);
      check("busy_low", 32'(Busy), 32'd0);
      e.adr = 32'h20; e.rd = 32'h20202020; e.err = 1'b0; e.cyc = cycle + LAT;
      sb.push_back(e);
      @(negedge clk);
      MemReq = 1'b0;
      wait_ready(start + 2, "busy_seq_timeout");
      repeat (2) @(negedge clk);

      // Reset while a write waits: outputs clear at once and the write never lands.
      @(negedge clk);
      MemReq = 1'b1; MemWrite = 1'b1; Adr = 32'h8; WriteData = 32'h55AA55AA;
      @(negedge clk);
      MemReq = 1'b0;
      check("busy_before_reset", 32'(Busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rdata", ReadData, 32'h0);
      check("async_busy", 32'(Busy), 32'd0);
      check("async_ready", 32'(MemReady), 32'd0);
      check("async_adrerr", 32'(AdrErr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_req(1'b0, 32'h8, 32'h0, 32'h11111111, 1'b0);

      // LATENCY=1 and LATENCY=4 instances: seed two words, then back-to-back reads.
      @(negedge clk);
      l_we = 1'b1; l_adr = 32'h0; l_wd = 32'h01010101; l_req = 1'b1;
      @(negedge clk);
      l_req = 1'b0;
      repeat (6) @(negedge clk);
      l_adr = 32'h4; l_wd = 32'h02020202; l_req = 1'b1;
      @(negedge clk);
      l_req = 1'b0;
      repeat (6) @(negedge clk);
      l_we = 1'b0; l_rd_phase = 1'b1; l_req = 1'b1;
      for (int k = 0; k < 30 && (l1_n < 2 || l4_n < 2); k++) @(negedge clk);
      l_req = 1'b0;
      check("l1_reads_seen", 32'(l1_n >= 2), 32'd1);
      check("l4_reads_seen", 32'(l4_n >= 2), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
